// File: rtl/byte_transmitter_mux.sv
// -----------------------------------------------------------------------------
// byte_transmitter_mux
//
// Purpose:
//   Shifts a WIDTH-bit word (normally the JTAG IDCODE) out LSB-first. One bit
//   is emitted on each rising clock edge where enable is high. A 2:1 mux then
//   chooses between that serial stream and the TAP controller's own TDO bit
//   to drive the single TDO line. The block sits in the TCK domain, between
//   the TAP state machine and the TDO pin.
//
// Ports:
//   clk         in   1      TCK; all state updates on the rising edge
//   reset       in   1      synchronous, active-high; clears serialiser state
//   enable      in   1      1 = shift one bit this cycle, 0 = hold
//   in          in   WIDTH  word to serialise; sampled bit by bit as it shifts
//   tap_bit     in   1      TAP-controller TDO value
//   select_tap  in   1      1 = out follows tap_bit, 0 = out follows serial_out
//   serial_out  out  1      registered serial bit
//   done        out  1      registered; sticky once all WIDTH bits are emitted
//   out         out  1      combinational mux output to TDO
// -----------------------------------------------------------------------------
module byte_transmitter_mux #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [WIDTH-1:0] in,
    input  logic             tap_bit,
    input  logic             select_tap,
    output logic             serial_out,
    output logic             done,
    output logic             out
);

    // IDX_W bits address any bit of the word. The counter has one extra bit so
    // that it can also hold the value WIDTH when WIDTH is a power of two.
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int CNT_W = IDX_W + 1;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] bit_idx_q, bit_idx_d;
    logic             serial_q,  serial_d;
    logic             done_q,    done_d;

    // Next-state logic.
    // The input word is read at the bit currently being shifted out; it is
    // not latched. Changing 'in' in the middle of a word therefore affects
    // only the bits that have not been sent yet.
    always_comb begin
        bit_idx_d = bit_idx_q;
        serial_d  = serial_q;
        done_d    = done_q;

        if (done_q) begin
            // Word finished: hold the counter and keep the line quiet until
            // reset.
            serial_d = 1'b0;
        end else if (enable) begin
            serial_d  = in[bit_idx_q[IDX_W-1:0]];
            bit_idx_d = bit_idx_q + CNT_ONE;
            // done rises on the same edge that shifts out the last bit.
            if (bit_idx_q == LAST_IDX) begin
                done_d = 1'b1;
            end
        end
    end

    // State registers. reset takes priority over enable.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_idx_q <= '0;
            serial_q  <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            bit_idx_q <= bit_idx_d;
            serial_q  <= serial_d;
            done_q    <= done_d;
        end
    end

    assign serial_out = serial_q;
    assign done       = done_q;

    // TDO mux: purely combinational, so it adds no latency.
    assign out = select_tap ? tap_bit : serial_q;

endmodule

// File: tb/tb_byte_transmitter_mux.sv
// -----------------------------------------------------------------------------
// tb_byte_transmitter_mux
//
// Directed testbench for byte_transmitter_mux. It serialises the IDCODE
// 32'h000FAF01 under continuous and gapped enable. It also covers the
// behaviour after done, reset in the middle of a word, a change to 'in' in
// the middle of a word, and the TDO mux.
// -----------------------------------------------------------------------------
module tb_byte_transmitter_mux;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             enable;
    logic [WIDTH-1:0] in;
    logic             tap_bit;
    logic             select_tap;
    logic             serial_out;
    logic             done;
    logic             out;

    int n_checks;
    int n_pass;

    // Expected serial sequence for 32'h000FAF01, written out by hand (LSB first).
    logic [31:0] idcode;
    logic        exp_bits [32];
    logic [31:0] alt_word;

    byte_transmitter_mux #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .in         (in),
        .tap_bit    (tap_bit),
        .select_tap (select_tap),
        .serial_out (serial_out),
        .done       (done),
        .out        (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it before checking.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        enable = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int k;
        n_checks = 0;
        n_pass   = 0;
        idcode   = 32'h000FAF01;
        alt_word = 32'hFFFF_FFFB;   // bit2 = 0, bit3 = 1
        // 1,0,0,0,0,0,0,0, 1,1,1,1,0,1,0,1, 1,1,1,1, then 12 zeros
        for (int i = 0; i < 32; i++) exp_bits[i] = 1'b0;
        exp_bits[0]  = 1'b1;
        exp_bits[8]  = 1'b1; exp_bits[9]  = 1'b1; exp_bits[10] = 1'b1; exp_bits[11] = 1'b1;
        exp_bits[13] = 1'b1; exp_bits[15] = 1'b1;
        exp_bits[16] = 1'b1; exp_bits[17] = 1'b1; exp_bits[18] = 1'b1; exp_bits[19] = 1'b1;

        in         = idcode;
        tap_bit    = 1'b0;
        select_tap = 1'b0;
        enable     = 1'b0;

        // Reset state.
        do_reset();
        check_val("rst_serial", 32'(serial_out), 32'd0);
        check_val("rst_done",   32'(done),       32'd0);
        check_val("rst_out",    32'(out),        32'd0);

        // Continuous shifting of the IDCODE.
        enable = 1'b1;
        for (int i = 0; i < 32; i++) begin
            tick();
            check_val($sformatf("cont_bit%0d", i),  32'(serial_out), 32'(exp_bits[i]));
            check_val($sformatf("cont_done%0d", i), 32'(done),       32'(i == 31));
            check_val($sformatf("cont_out%0d", i),  32'(out),        32'(exp_bits[i]));
        end

        // After done: sticky done and a quiet line, whatever enable does.
        for (int i = 0; i < 5; i++) begin
            enable = (i != 2);
            tick();
            check_val($sformatf("post_done%0d", i),   32'(done),       32'd1);
            check_val($sformatf("post_serial%0d", i), 32'(serial_out), 32'd0);
        end
        do_reset();
        check_val("rst2_done",   32'(done),       32'd0);
        check_val("rst2_serial", 32'(serial_out), 32'd0);
        enable = 1'b1;
        tick();
        check_val("rst2_bit0", 32'(serial_out), 32'd1);

        // Gapped enable (1,0,1,0,...): bits hold during disabled cycles.
        do_reset();
        k = 0;
        for (int c = 0; c < 64; c++) begin
            enable = ((c % 2) == 0);
            tick();
            if ((c % 2) == 0) k++;
            check_val($sformatf("gap_bit_c%0d", c),  32'(serial_out), 32'(exp_bits[k-1]));
            check_val($sformatf("gap_done_c%0d", c), 32'(done),       32'(k == 32));
        end

        // Reset after 10 bits, asserted while enable is still high.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_val("mid_bit9", 32'(serial_out), 32'(exp_bits[9]));
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check_val("mid_rst_serial", 32'(serial_out), 32'd0);
        check_val("mid_rst_done",   32'(done),       32'd0);
        tick();
        check_val("mid_restart_bit0", 32'(serial_out), 32'd1);
        tick();
        check_val("mid_restart_bit1", 32'(serial_out), 32'd0);

        // Change 'in' mid-word: only the bits not yet sent follow the new word.
        in = alt_word;
        tick();
        check_val("chg_bit2", 32'(serial_out), 32'd0);
        tick();
        check_val("chg_bit3", 32'(serial_out), 32'd1);
        in = idcode;

        // TDO mux: select_tap=1 follows tap_bit immediately, even while the word shifts.
        do_reset();
        enable     = 1'b1;
        select_tap = 1'b1;
        tap_bit    = 1'b1;
        #1;
        check_val("mux_tap1_comb", 32'(out), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_val($sformatf("mux_shift_serial%0d", i), 32'(serial_out), 32'(exp_bits[i]));
            check_val($sformatf("mux_tap1_out%0d", i),     32'(out),        32'd1);
        end
        tap_bit = 1'b0;
        #1;
        check_val("mux_tap0_comb", 32'(out), 32'd0);
        // serial_out is currently bit 3 = 0; the next two edges give bits 4 and 5.
        select_tap = 1'b0;
        tap_bit    = 1'b1;
        for (int i = 4; i < 12; i++) begin
            tick();
            check_val($sformatf("mux_ser_out%0d", i), 32'(out), 32'(exp_bits[i]));
        end
        // bit 11 = 1 is on serial_out now; the mux must switch with no clock edge.
        select_tap = 1'b1;
        tap_bit    = 1'b0;
        #1;
        check_val("mux_switch_tap", 32'(out), 32'd0);
        select_tap = 1'b0;
        #1;
        check_val("mux_switch_ser", 32'(out), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
